// File: rtl/card_pkg.sv
// card_pkg: deck constants, card field layout, dealer states and LFSR step.
package card_pkg;
  localparam int DECK_SIZE = 52;
  localparam int RANKS = 13;
  localparam int HAND_MAX = 3;
  localparam logic [5:0] CARD_EMPTY = 6'd0;
  localparam int SUIT_MSB = 5;
  localparam int SUIT_LSB = 4;
  localparam int RANK_MSB = 3;
  localparam int RANK_LSB = 0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PROBE = 2'd2;
  // Fibonacci LFSR with taps 16,14,13,11, shifting toward the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
endpackage

// File: rtl/idx_to_card.sv
// idx_to_card: maps deck index 0..51 to {suit, rank} with rank 1..13, no divider.
module idx_to_card
  import card_pkg::*;
(
  input  logic [5:0] i_idx,
  output logic [5:0] o_card
);
  logic [1:0] w_suit;
  logic [5:0] w_off;
  logic [3:0] w_rank;
  always_comb begin
    w_suit = i_idx >= 6'(3 * RANKS) ? 2'd3 : i_idx >= 6'(2 * RANKS) ? 2'd2 : i_idx >= 6'(RANKS) ? 2'd1 : 2'd0;
    w_off = i_idx >= 6'(3 * RANKS) ? 6'(3 * RANKS) : i_idx >= 6'(2 * RANKS) ? 6'(2 * RANKS) : i_idx >= 6'(RANKS) ? 6'(RANKS) : 6'd0;
    w_rank = 4'(i_idx - w_off + 6'd1);
    o_card = CARD_EMPTY;
    o_card[SUIT_MSB:SUIT_LSB] = w_suit;
    o_card[RANK_MSB:RANK_LSB] = w_rank;
  end
endmodule

// File: rtl/card_dealer.sv
// card_dealer: draws cards without replacement from a 52-card deck using a
// free-running LFSR and linear probing, building a hand of up to 3 cards.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal,
  input  logic       new_hand,
  input  logic       shuffle,
  output logic [5:0] card1,
  output logic [5:0] card2,
  output logic [5:0] card3,
  output logic [1:0] num,
  output logic       busy,
  output logic       dealt,
  output logic       deck_empty
);
  localparam logic [15:0] SEED = LFSR_SEED == 16'd0 ? 16'h0001 : LFSR_SEED;
  logic [15:0] r_lfsr;
  logic [51:0] r_used;
  logic [5:0] r_idx, r_cnt;
  logic [1:0] r_state;
  logic [5:0] w_card, w_fetch, w_next_idx;
  logic w_idle, w_accept, w_hit;
  idx_to_card u_map (.i_idx(r_idx), .o_card(w_card));
  // the count guard also covers the cycle between the last commit and deck_empty rising
  always_comb begin
    w_idle = r_state == S_IDLE;
    w_accept = deal && num != 2'(HAND_MAX) && r_cnt != 6'(DECK_SIZE);
    w_hit = !r_used[r_idx];
    w_fetch = r_lfsr[5:0] >= 6'(DECK_SIZE) ? r_lfsr[5:0] - 6'(DECK_SIZE) : r_lfsr[5:0];
    w_next_idx = r_idx == 6'(DECK_SIZE - 1) ? 6'd0 : r_idx + 6'd1;
  end
  assign busy = !w_idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
      r_used <= '0;
      r_idx <= '0;
      r_cnt <= '0;
      r_state <= S_IDLE;
      card1 <= CARD_EMPTY;
      card2 <= CARD_EMPTY;
      card3 <= CARD_EMPTY;
      num <= '0;
      dealt <= 1'b0;
      deck_empty <= 1'b0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      dealt <= 1'b0;
      deck_empty <= r_cnt == 6'(DECK_SIZE);
      case (r_state)
        S_IDLE: begin
          if (shuffle || new_hand) begin
            card1 <= CARD_EMPTY;
            card2 <= CARD_EMPTY;
            card3 <= CARD_EMPTY;
            num <= '0;
          end
          if (shuffle) begin
            r_used <= '0;
            r_cnt <= '0;
            deck_empty <= 1'b0;
          end else if (!new_hand && w_accept) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_idx <= w_fetch;
          r_state <= S_PROBE;
        end
        S_PROBE: begin
          if (w_hit) begin
            if (num == 2'd0) card1 <= w_card;
            else if (num == 2'd1) card2 <= w_card;
            else card3 <= w_card;
            num <= num + 2'd1;
            r_used[r_idx] <= 1'b1;
            r_cnt <= r_cnt + 6'd1;
            dealt <= 1'b1;
            r_state <= S_IDLE;
          end else r_idx <= w_next_idx;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
